// File: rtl/mult_shift_add_32bit_pkg.sv
// Shared constants for the sequential shift-and-add multiplier:
// FSM state encodings and the index of the final iteration.
package mult_shift_add_32bit_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int ITER_LAST = 31;

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit ripple-carry adder with carry-out, no carry-in.
// Built from a chain of single-bit full-adder cells.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        carry_out
);

  logic [32:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[32];

endmodule

// File: rtl/mult_shift_add_32bit.sv
// Unsigned 32x32 -> 64 sequential multiplier: one add-and-shift step per clock
// through a single full_adder_32bit, with a start/busy/done handshake.
module mult_shift_add_32bit
  import mult_shift_add_32bit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The adder instance is hard-wired to 32 bits, so no other width can work.
  if (WIDTH != 32) begin : g_width_check
    $error("mult_shift_add_32bit: only WIDTH=32 is supported");
  end

  state_t               state_q, state_d;
  logic [ITER_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     addSum;
  logic                 addCarry;
  logic [WIDTH:0]       sum33;
  logic                 lastIter;

  assign addend = lo_q[0] ? m_q : '0;

  full_adder_32bit u_adder (
    .a         (hi_q),
    .b         (addend),
    .sum       (addSum),
    .carry_out (addCarry)
  );

  // The carry re-enters as the new MSB of hi once the pair is shifted right.
  assign sum33    = {addCarry, addSum};
  assign lastIter = (cnt_q == ITER_W'(ITER_LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        hi_d  = sum33[WIDTH:1];
        lo_d  = {sum33[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + ITER_W'(1);
        // Product is published only from the final step so it never shows partial sums.
        if (lastIter) begin
          state_d   = S_DONE;
          product_d = {sum33[WIDTH:1], sum33[0], lo_q[WIDTH-1:1]};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_shift_add_32bit.sv
// Directed and randomised checks of mult_shift_add_32bit against a 64-bit
// reference product, using a queue of expected results popped on each done.
module tb_mult_shift_add_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int          assertsEval = 0;
  int          failures = 0;
  int          cycleCount = 0;
  int          acceptCycle = 0;
  int          doneCycle = 0;
  int          prevDoneCycle = 0;
  logic [63:0] expectQ[$];

  mult_shift_add_32bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertsEval++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    assertsEval++;
    failures++;
    $error("[TB] FAIL %s: observed no done within bound, expected done", tag);
  endtask

  // Called at a negedge with ready high; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input bit holdStart);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, opA};
    wb = {32'd0, opB};
    start = 1'b1;
    a = opA;
    b = opB;
    expectQ.push_back(wa * wb);
    @(negedge clk);
    acceptCycle = cycleCount;
    if (!holdStart) start = 1'b0;
  endtask

  // Waits for done, checks latency/product, then that done drops and ready returns.
  task automatic waitAndCheck(input string tag);
    bit seen;
    logic [63:0] exp;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      reportTimeout(tag);
      return;
    end
    doneCycle = cycleCount;
    checkOutput({tag, "_latency"}, 64'(doneCycle - acceptCycle), 64'd32);
    if (expectQ.size() == 0) begin
      reportTimeout({tag, "_emptyq"});
    end else begin
      exp = expectQ.pop_front();
      checkOutput({tag, "_product"}, product, exp);
    end
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int nDone;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", product, 64'd0);

    applyStimulus(32'd3, 32'd5, 1'b0);
    checkOutput("basic_busy", 64'(busy), 64'd1);
    waitAndCheck("basic");

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitAndCheck("max");
    checkOutput("max_const", product, 64'hFFFF_FFFE_0000_0001);

    applyStimulus(32'd0, 32'h1234_5678, 1'b0);
    waitAndCheck("zero_a");
    applyStimulus(32'h1234_5678, 32'd1, 1'b0);
    waitAndCheck("identity");
    applyStimulus(32'hDEAD_BEEF, 32'd0, 1'b0);
    waitAndCheck("zero_b");

    // A second start mid-run, with changed operands, must be ignored.
    applyStimulus(32'd7, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    a = 32'd2;
    b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    waitAndCheck("busy_start");
    checkOutput("busy_start_63", product, 64'd63);
    countDones(40, nDone);
    checkOutput("busy_start_extra_done", 64'(nDone), 64'd0);

    applyStimulus(32'd100, 32'd100, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_ready", 64'(ready), 64'd1);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expectQ.delete();
    countDones(40, nDone);
    checkOutput("midreset_no_done", 64'(nDone), 64'd0);
    applyStimulus(32'd6, 32'd7, 1'b0);
    waitAndCheck("after_reset");

    // Start held high: each done is followed by an acceptance two edges later.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 1) ra = 32'hFFFF_FFFF;
      if (i == 1) rb = 32'hFFFF_FFFF;
      if (!ready) begin
        reportTimeout("rand_not_ready");
        break;
      end
      applyStimulus(ra, rb, (i != 999));
      waitAndCheck("rand");
      if (i > 0) checkOutput("rand_spacing", 64'(doneCycle - prevDoneCycle), 64'd34);
      prevDoneCycle = doneCycle;
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertsEval, failures);
    $finish;
  end

endmodule
